// File: rtl/word_serializer_sel_if.sv
//------------------------------------------------------------------------------
// word_serializer_sel_if : word-in / serial-beat-out handshake bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface word_serializer_sel_if #(
  parameter int W = 8
);
  localparam int SEL_W = $clog2(W);

  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] sel;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_last;
  logic             busy;

  // master: upstream word source plus downstream beat sink
  modport master (
    output in_data, in_valid, ser_ready,
    input  in_ready, sel, ser_out, ser_valid, ser_last, busy
  );

  modport slave (
    input  in_data, in_valid, ser_ready,
    output in_ready, sel, ser_out, ser_valid, ser_last, busy
  );
endinterface

`default_nettype wire

// File: rtl/word_serializer_sel.sv
//------------------------------------------------------------------------------
// word_serializer_sel : parallel word to serial bit stream with mux select out
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module word_serializer_sel #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic             clock,
  input  wire logic             reset,
  word_serializer_sel_if.slave  bus
);
  localparam int SEL_W = $clog2(W);
  localparam logic [SEL_W-1:0] FIRST = SEL_W'(MSB_FIRST ? W - 1 : 0);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(MSB_FIRST ? 0 : W - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [W-1:0]     r_word,  w_word_nxt;
  logic [SEL_W-1:0] r_sel,   w_sel_nxt;

  logic             w_ser_valid;
  logic             w_ser_last;
  logic             w_in_ready;
  logic             w_beat;
  logic             w_load;
  logic [SEL_W-1:0] w_sel_step;

  assign w_ser_valid = (r_state == S_SHIFT);
  assign w_ser_last  = w_ser_valid & (r_sel == LAST);
  // Taking a new word on the final beat gives back-to-back words with no bubble
  assign w_in_ready  = ~reset & ((r_state == S_IDLE) | (w_ser_last & bus.ser_ready));
  assign w_beat      = w_ser_valid & bus.ser_ready;
  assign w_load      = bus.in_valid & w_in_ready;
  assign w_sel_step  = MSB_FIRST ? (r_sel - SEL_W'(1)) : (r_sel + SEL_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_sel_nxt   = r_sel;
    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_word_nxt  = bus.in_data;
          w_sel_nxt   = FIRST;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_beat) begin
          if (!w_ser_last) begin
            w_sel_nxt = w_sel_step;
          end else if (w_load) begin
            w_word_nxt = bus.in_data;
            w_sel_nxt  = FIRST;
          end else begin
            w_sel_nxt   = FIRST;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_sel_nxt   = FIRST;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_sel   <= FIRST;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.sel       = r_sel;
  assign bus.ser_out   = r_word[r_sel];
  assign bus.ser_valid = w_ser_valid;
  assign bus.ser_last  = w_ser_last;
  assign bus.busy      = w_ser_valid;

endmodule

`default_nettype wire

// File: tb/tb_word_serializer_sel.sv
//------------------------------------------------------------------------------
// tb_word_serializer_sel : queue-model bench over three width/order variants
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_word_serializer_sel;
  localparam int NI = 3;

  // Variant 0: W=8 MSB first; 1: W=2 LSB first; 2: W=5 LSB first
  function automatic int wid_of(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 2 : 5);
  endfunction

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       ser_ready = 1'b0;
  logic [7:0] in_data = 8'h00;

  always #5 clk = ~clk;

  logic       ir_o [NI];
  logic       so_o [NI];
  logic       sv_o [NI];
  logic       sl_o [NI];
  logic       bz_o [NI];
  logic [7:0] sel_o[NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int WW = wid_of(g);
    localparam bit MF = (g == 0);

    word_serializer_sel_if #(.W(WW)) bus ();

    assign bus.in_data   = in_data[WW-1:0];
    assign bus.in_valid  = in_valid;
    assign bus.ser_ready = ser_ready;

    word_serializer_sel #(.W(WW), .MSB_FIRST(MF)) u_dut (
      .clock (clk),
      .reset (reset),
      .bus   (bus)
    );

    assign ir_o[g]  = bus.in_ready;
    assign so_o[g]  = bus.ser_out;
    assign sv_o[g]  = bus.ser_valid;
    assign sl_o[g]  = bus.ser_last;
    assign bz_o[g]  = bus.busy;
    assign sel_o[g] = 8'(bus.sel);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Pending beats of the current word, front = beat on the bus now
  int qb[NI][$];
  int qs[NI][$];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int n;
      int b;
      bit eir;
      n   = qb[i].size();
      eir = !reset && (n == 0 || (n == 1 && ser_ready));
      check_val($sformatf("in_ready[%0d]", i), 32'(ir_o[i]), 32'(eir));
      check_val($sformatf("ser_valid[%0d]", i), 32'(sv_o[i]), 32'(n > 0));
      check_val($sformatf("busy[%0d]", i), 32'(bz_o[i]), 32'(n > 0));
      if (n > 0) begin
        check_val($sformatf("ser_out[%0d]", i), 32'(so_o[i]), 32'(qb[i][0]));
        check_val($sformatf("sel[%0d]", i), 32'(sel_o[i]), 32'(qs[i][0]));
        check_val($sformatf("ser_last[%0d]", i), 32'(sl_o[i]), 32'(n == 1));
      end else begin
        check_val($sformatf("ser_last_idle[%0d]", i), 32'(sl_o[i]), 32'd0);
      end

      if (reset) begin
        qb[i].delete();
        qs[i].delete();
      end else begin
        if (n > 0 && ser_ready) begin
          void'(qb[i].pop_front());
          void'(qs[i].pop_front());
        end
        if (in_valid && eir) begin
          for (int k = 0; k < wid_of(i); k++) begin
            b = (i == 0) ? wid_of(i) - 1 - k : k;
            qb[i].push_back(int'(in_data[b]));
            qs[i].push_back(b);
          end
        end
      end
    end
  end

  task automatic step(input logic rs, input logic v, input logic [7:0] d, input logic sr);
    @(posedge clk);
    #1;
    reset     = rs;
    in_valid  = v;
    in_data   = d;
    ser_ready = sr;
  endtask

  initial begin
    step(1'b1, 1'b0, 8'h00, 1'b0);
    // Single word 8'hA5 (low bits give 2'b01 and 5'b00101 on the narrow variants)
    step(1'b0, 1'b1, 8'hA5, 1'b1);
    repeat (10) step(1'b0, 1'b0, 8'h00, 1'b1);
    // Backpressure after three beats
    step(1'b0, 1'b1, 8'hA5, 1'b1);
    repeat (3) step(1'b0, 1'b0, 8'h5A, 1'b1);
    repeat (3) step(1'b0, 1'b0, 8'hC3, 1'b0);
    repeat (8) step(1'b0, 1'b0, 8'h00, 1'b1);
    // Back-to-back words
    step(1'b0, 1'b1, 8'hA5, 1'b1);
    repeat (8) step(1'b0, 1'b1, 8'h3C, 1'b1);
    repeat (10) step(1'b0, 1'b0, 8'h00, 1'b1);
    // Reset mid-word with in_data churn, then a fresh word
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    repeat (3) step(1'b0, 1'b0, 8'h55, 1'b1);
    step(1'b1, 1'b0, 8'hAA, 1'b1);
    step(1'b0, 1'b1, 8'h0F, 1'b1);
    repeat (10) step(1'b0, 1'b0, 8'h00, 1'b1);
    // Random traffic
    repeat (1500) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           8'($urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (12) step(1'b0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
